op_dispatcher: RTL and testbench
================================

# op_dispatcher

Sequencer between the op source (parser/FIFO) and the motion op handlers. Accepts one `Op_st` at a time over a valid/ready handshake, holds it stable on the shared `op` bus, and drives the master side of `OpHandler_IF` toward the linear or circular handler. Waits for that handler to finish, then reports completion. Mode ops (G90/G91) are held on the bus for `PositionKeeper` with no handler involved.

## Interface
- `MODE_HOLD_CYCLES`, default 4: cycles a G90/G91 op stays on `op` before completion; range 1..15.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles in TRIGGER waiting for the handler to drop `rdy`; 16-bit counter.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low; sampled on rising `clk`, independent of `clk_en`.
- `clk_en` in 1: state, counters and registers advance only when high.
- `op_in` in `Op_st`: upstream op.
- `op_valid` in 1: `op_in` is valid.
- `op_rdy` out 1: dispatcher is in IDLE and can accept an op.
- `op` out `Op_st`: registered op broadcast to the handlers and `PositionKeeper`.
- `lin_intf` `OpHandler_IF.master`: linear handler (G00/G01); drives `trigger`, samples `rdy`.
- `circ_intf` `OpHandler_IF.master`: circular handler (G02/G03).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when an op completes.
- `err_unsupported` out 1: sticky; an op with an unknown cmd was dropped.
- `err_timeout` out 1: sticky; a handler never acknowledged its trigger.

## Operation
- States: IDLE, TRIGGER, WAIT_DONE, MODE_HOLD, DONE.
- **IDLE:** `op_rdy`=1.
  - On `op_valid` with `clk_en`, register `op_in` into `op`, clear both sticky errors and decode `cmd`.
  - G00/G01 select lin; G02/G03 select circ; both go to TRIGGER.
  - G90/G91 go to MODE_HOLD.
  - Any other cmd: set `err_unsupported`, leave `op` updated, go to DONE.
- **TRIGGER:** selected `trigger`=1, the other 0. Timeout counter increments each enabled cycle.
  - If the selected `rdy` is sampled 0, go to WAIT_DONE.
  - If the counter reaches `TIMEOUT_CYCLES`-1 with `rdy` still 1, set `err_timeout` and go to DONE.
- **WAIT_DONE:** `trigger`=0. Go to DONE when the selected `rdy` is sampled 1.
- **MODE_HOLD:** no triggers. Counter runs; go to DONE after `MODE_HOLD_CYCLES` enabled cycles.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `op` is modified only on acceptance in IDLE. It stays stable through completion and after it.
- The `rdy` of the non-selected handler is ignored in all states.
- At most one `trigger` is high at any time.
- Reset in any state (including mid-handshake) returns to IDLE next edge and forces every output to its reset value. The handler is expected to be reset by the same signal.

## Timing
- Reset values: `op_rdy`=0 during reset, 1 on the first enabled cycle after release. `op`=all zero; both triggers 0; `busy`, `done`, `err_unsupported`, `err_timeout` all 0.
- All outputs are registered.
- Accept at edge N; `busy`=1 and `trigger`=1 from N+1.
- Handler `rdy` low sampled at edge M; `trigger`=0 from M+1.
- `rdy` high sampled at edge K in WAIT_DONE; `done` is high from K+1 to K+2. `op_rdy`=1 from K+2, and the next op can be accepted at K+2.
- Mode op: `done` is high `MODE_HOLD_CYCLES`+1 cycles after acceptance.
- Unsupported op: `done` is high one cycle after acceptance.
- When `clk_en`=0, every output holds and no counter advances.
- `rdy` already low when TRIGGER is entered counts as acknowledged.

## Test plan
- **Circular op:** G02 (50, 50, 50, 0, flags=1) with a real `CircularOpHandler`. Expect `circ_intf.trigger` rising 1 cycle after accept and falling 1 cycle after `rdy` falls. `lin` trigger must stay 0. Expect exactly one `done` pulse, and `op` unchanged until the next accept.
- **Back-to-back ops:** G03 offered with `op_valid` held high from the start, followed by G01. The G01 must be accepted exactly 2 cycles after `done` of the G03 and routed to `lin_intf`.
- **Mode op:** G91 with `MODE_HOLD_CYCLES`=4. No trigger fires; `done` is high 5 cycles after accept; `PositionKeeper` switches to relative mode.
- **Error paths:**
  - Unsupported cmd: `err_unsupported`=1 and `done` the next cycle. Both remain cleared by the next accepted G02.
  - Timeout: handler stub with `rdy` stuck high, `TIMEOUT_CYCLES`=16. `err_timeout`=1, `trigger` drops, `done` about 17 cycles after accept.
- **`clk_en` gating:** toggle `clk_en` 1-of-3 during a G02. The handshake sequence and the `done` count are identical; latencies scale by the enable ratio.
- **Reset mid-operation:** assert `reset` low for 1 cycle while in WAIT_DONE. All outputs reach their reset values the next edge; after release, a fresh G02 completes normally.

Source files
------------

// File: rtl/op_dispatcher_if.sv
// Trigger/rdy handshake between the dispatcher (master) and one op handler.

interface OpHandler_IF;
    logic trigger;
    logic rdy;

    modport master (output trigger, input rdy);
    modport slave  (input trigger, output rdy);
endinterface

// File: rtl/op_dispatcher.sv
// Op sequencer: accepts one motion/mode op, broadcasts it on the op bus and
// runs the trigger/rdy handshake with the linear or circular handler.

package op_pkg;
    localparam logic [7:0] CMD_G00 = 8'd0;
    localparam logic [7:0] CMD_G01 = 8'd1;
    localparam logic [7:0] CMD_G02 = 8'd2;
    localparam logic [7:0] CMD_G03 = 8'd3;
    localparam logic [7:0] CMD_G90 = 8'd90;
    localparam logic [7:0] CMD_G91 = 8'd91;

    typedef struct packed {
        logic [7:0]         cmd;
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] i;
        logic signed [15:0] j;
        logic [7:0]         flags;
    } Op_st;
endpackage

module op_dispatcher
    import op_pkg::*;
#(
    parameter int MODE_HOLD_CYCLES = 4,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  Op_st        op_in,
    input  logic        op_valid,
    output logic        op_rdy,
    output Op_st        op,
    OpHandler_IF.master lin_intf,
    OpHandler_IF.master circ_intf,
    output logic        busy,
    output logic        done,
    output logic        err_unsupported,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIGGER,
        S_WAIT_DONE,
        S_MODE_HOLD,
        S_DONE
    } state_e;

    localparam logic [15:0] HOLD_LAST = 16'(MODE_HOLD_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_e      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_sel_circ, w_sel_circ_nxt;
    logic        r_err_unsup, w_err_unsup_nxt;
    logic        r_err_to, w_err_to_nxt;
    Op_st        r_op;

    logic        r_op_rdy, r_busy, r_done, r_lin_trig, r_circ_trig;
    logic        w_op_rdy_nxt, w_busy_nxt, w_done_nxt, w_lin_trig_nxt, w_circ_trig_nxt;

    logic        w_accept;
    logic        w_sel_rdy;

    // NOTE: acceptance is qualified by the registered op_rdy, so an op offered
    // while op_rdy is still low right after reset release is never swallowed.
    assign w_accept  = (r_state == S_IDLE) && r_op_rdy && op_valid;
    assign w_sel_rdy = r_sel_circ ? circ_intf.rdy : lin_intf.rdy;

    // NOTE: reset is checked ahead of clk_en so it takes effect on any edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel_circ  <= 1'b0;
            r_err_unsup <= 1'b0;
            r_err_to    <= 1'b0;
            r_op        <= '0;
        end else if (clk_en) begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel_circ  <= w_sel_circ_nxt;
            r_err_unsup <= w_err_unsup_nxt;
            r_err_to    <= w_err_to_nxt;
            if (w_accept) begin
                r_op <= op_in;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sel_circ_nxt  = r_sel_circ;
        w_err_unsup_nxt = r_err_unsup;
        w_err_to_nxt    = r_err_to;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt       = '0;
                    w_err_unsup_nxt = 1'b0;
                    w_err_to_nxt    = 1'b0;
                    case (op_in.cmd)
                        CMD_G00, CMD_G01: begin
                            w_sel_circ_nxt = 1'b0;
                            w_state_nxt    = S_TRIGGER;
                        end
                        CMD_G02, CMD_G03: begin
                            w_sel_circ_nxt = 1'b1;
                            w_state_nxt    = S_TRIGGER;
                        end
                        CMD_G90, CMD_G91: w_state_nxt = S_MODE_HOLD;
                        default: begin
                            w_err_unsup_nxt = 1'b1;
                            w_state_nxt     = S_DONE;
                        end
                    endcase
                end
            end
            S_TRIGGER: begin
                if (!w_sel_rdy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_err_to_nxt = 1'b1;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_WAIT_DONE: begin
                if (w_sel_rdy) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_MODE_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        w_op_rdy_nxt    = (w_state_nxt == S_IDLE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = (w_state_nxt == S_DONE);
        w_lin_trig_nxt  = (w_state_nxt == S_TRIGGER) && !w_sel_circ_nxt;
        w_circ_trig_nxt = (w_state_nxt == S_TRIGGER) && w_sel_circ_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op_rdy    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_lin_trig  <= 1'b0;
            r_circ_trig <= 1'b0;
        end else if (clk_en) begin
            r_op_rdy    <= w_op_rdy_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_lin_trig  <= w_lin_trig_nxt;
            r_circ_trig <= w_circ_trig_nxt;
        end
    end

    assign op_rdy            = r_op_rdy;
    assign op                = r_op;
    assign busy              = r_busy;
    assign done              = r_done;
    assign err_unsupported   = r_err_unsup;
    assign err_timeout       = r_err_to;
    assign lin_intf.trigger  = r_lin_trig;
    assign circ_intf.trigger = r_circ_trig;

endmodule

// File: tb/tb_op_dispatcher.sv
// Directed bench for op_dispatcher; the bench itself plays both handlers.

module tb_op_dispatcher;
    import op_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;
    Op_st op_in;
    logic op_valid;
    logic op_rdy;
    Op_st op;
    logic busy, done, err_unsupported, err_timeout;

    OpHandler_IF lin_if ();
    OpHandler_IF circ_if ();

    int n_checks = 0;
    int n_fail   = 0;

    op_dispatcher #(
        .MODE_HOLD_CYCLES(4),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .op_in          (op_in),
        .op_valid       (op_valid),
        .op_rdy         (op_rdy),
        .op             (op),
        .lin_intf       (lin_if),
        .circ_intf      (circ_if),
        .busy           (busy),
        .done           (done),
        .err_unsupported(err_unsupported),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    function automatic Op_st mk_op(input logic [7:0] cmd, input int x, input int y,
                                   input int i, input int j, input logic [7:0] flags);
        Op_st o;
        o.cmd   = cmd;
        o.x     = 16'(x);
        o.y     = 16'(y);
        o.i     = 16'(i);
        o.j     = 16'(j);
        o.flags = flags;
        return o;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic offer(input Op_st o);
        op_in    = o;
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        n_checks++; if (op_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_op_rdy: got %b exp 0", op_rdy); end
        n_checks++; if (op !== '0) begin n_fail++; $display("FAIL reset_op: got %h exp 0", op); end
        n_checks++; if ({busy, done, err_unsupported, err_timeout, lin_if.trigger, circ_if.trigger} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b exp 000000",
                               {busy, done, err_unsupported, err_timeout, lin_if.trigger, circ_if.trigger});
        end
        reset = 1'b1;
        step();
        n_checks++; if (op_rdy !== 1'b1) begin n_fail++; $display("FAIL release_op_rdy: got %b exp 1", op_rdy); end
    endtask

    task automatic test_circular();
        Op_st g02 = mk_op(CMD_G02, 50, 50, 50, 0, 8'd1);
        int   n_done = 0;
        offer(g02);
        n_checks++; if (circ_if.trigger !== 1'b1) begin n_fail++; $display("FAIL circ_trig_rise: got %b exp 1", circ_if.trigger); end
        n_checks++; if (lin_if.trigger !== 1'b0) begin n_fail++; $display("FAIL circ_lin_quiet: got %b exp 0", lin_if.trigger); end
        n_checks++; if (busy !== 1'b1 || op_rdy !== 1'b0) begin n_fail++; $display("FAIL circ_busy: got busy=%b op_rdy=%b exp 1/0", busy, op_rdy); end
        n_checks++; if (op !== g02) begin n_fail++; $display("FAIL circ_op: got %h exp %h", op, g02); end
        // The linear handler's rdy dropping must not count as an acknowledge.
        lin_if.rdy = 1'b0;
        step();
        n_checks++; if (circ_if.trigger !== 1'b1) begin n_fail++; $display("FAIL circ_ignore_lin: got trig %b exp 1", circ_if.trigger); end
        lin_if.rdy  = 1'b1;
        circ_if.rdy = 1'b0;
        step();
        n_checks++; if (circ_if.trigger !== 1'b0) begin n_fail++; $display("FAIL circ_trig_fall: got %b exp 0", circ_if.trigger); end
        repeat (2) begin
            step();
            if (done === 1'b1) n_done++;
        end
        circ_if.rdy = 1'b1;
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL circ_done: got %b exp 1", done); end
        if (done === 1'b1) n_done++;
        step();
        if (done === 1'b1) n_done++;
        step();
        if (done === 1'b1) n_done++;
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL circ_done_count: got %0d exp 1", n_done); end
        n_checks++; if (op_rdy !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL circ_idle: got op_rdy=%b busy=%b exp 1/0", op_rdy, busy); end
        n_checks++; if (op !== g02) begin n_fail++; $display("FAIL circ_op_hold: got %h exp %h", op, g02); end
    endtask

    task automatic test_back_to_back();
        Op_st g03 = mk_op(CMD_G03, -20, 10, 0, -15, 8'd2);
        Op_st g01 = mk_op(CMD_G01, 100, -100, 0, 0, 8'd0);
        op_in    = g03;
        op_valid = 1'b1;
        step();
        op_in = g01;
        n_checks++; if (op !== g03 || circ_if.trigger !== 1'b1) begin n_fail++; $display("FAIL b2b_g03_accept: got op=%h trig=%b exp %h/1", op, circ_if.trigger, g03); end
        circ_if.rdy = 1'b0;
        step();
        circ_if.rdy = 1'b1;
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_g03_done: got %b exp 1", done); end
        step();
        n_checks++; if (op !== g03 || op_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got op=%h op_rdy=%b exp %h/1", op, op_rdy, g03); end
        step();
        op_valid = 1'b0;
        n_checks++; if (op !== g01) begin n_fail++; $display("FAIL b2b_g01_accept: got %h exp %h", op, g01); end
        n_checks++; if (lin_if.trigger !== 1'b1 || circ_if.trigger !== 1'b0) begin
            n_fail++; $display("FAIL b2b_g01_route: got lin=%b circ=%b exp 1/0", lin_if.trigger, circ_if.trigger);
        end
        lin_if.rdy = 1'b0;
        step();
        lin_if.rdy = 1'b1;
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_g01_done: got %b exp 1", done); end
        step();
    endtask

    task automatic test_mode();
        Op_st g91 = mk_op(CMD_G91, 0, 0, 0, 0, 8'd0);
        offer(g91);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (done !== 1'b0 || lin_if.trigger !== 1'b0 || circ_if.trigger !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL mode_hold[%0d]: got done=%b lin=%b circ=%b busy=%b exp 0/0/0/1",
                                   k, done, lin_if.trigger, circ_if.trigger, busy);
            end
            step();
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mode_done: got %b exp 1", done); end
        n_checks++; if (op !== g91) begin n_fail++; $display("FAIL mode_op: got %h exp %h", op, g91); end
        step();
    endtask

    task automatic test_unsupported();
        Op_st bad = mk_op(8'd17, 1, 2, 3, 4, 8'd5);
        Op_st g02 = mk_op(CMD_G02, 7, 8, 9, 10, 8'd1);
        offer(bad);
        n_checks++; if (done !== 1'b1 || err_unsupported !== 1'b1) begin
            n_fail++; $display("FAIL unsup_done: got done=%b err=%b exp 1/1", done, err_unsupported);
        end
        n_checks++; if (op !== bad) begin n_fail++; $display("FAIL unsup_op: got %h exp %h", op, bad); end
        step();
        n_checks++; if (err_unsupported !== 1'b1 || op_rdy !== 1'b1) begin
            n_fail++; $display("FAIL unsup_sticky: got err=%b op_rdy=%b exp 1/1", err_unsupported, op_rdy);
        end
        offer(g02);
        n_checks++; if (err_unsupported !== 1'b0) begin n_fail++; $display("FAIL unsup_clear: got %b exp 0", err_unsupported); end
        circ_if.rdy = 1'b0;
        step();
        circ_if.rdy = 1'b1;
        step();
        step();
        n_checks++; if (err_unsupported !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL unsup_stay_clear: got unsup=%b to=%b exp 0/0", err_unsupported, err_timeout);
        end
    endtask

    task automatic test_timeout();
        offer(mk_op(CMD_G00, 5, 5, 0, 0, 8'd0));
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (lin_if.trigger !== 1'b1 || done !== 1'b0) begin
                n_fail++; $display("FAIL to_wait[%0d]: got trig=%b done=%b exp 1/0", k, lin_if.trigger, done);
            end
            step();
        end
        n_checks++; if (done !== 1'b1 || err_timeout !== 1'b1 || lin_if.trigger !== 1'b0) begin
            n_fail++; $display("FAIL to_fire: got done=%b err=%b trig=%b exp 1/1/0", done, err_timeout, lin_if.trigger);
        end
        step();
        n_checks++; if (err_timeout !== 1'b1 || op_rdy !== 1'b1) begin
            n_fail++; $display("FAIL to_sticky: got err=%b op_rdy=%b exp 1/1", err_timeout, op_rdy);
        end
    endtask

    task automatic hold2(input logic exp_trig, input logic exp_done);
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++; if (circ_if.trigger !== exp_trig || done !== exp_done || busy !== 1'b1) begin
                n_fail++; $display("FAIL gate_hold: got trig=%b done=%b busy=%b exp %b/%b/1",
                                   circ_if.trigger, done, busy, exp_trig, exp_done);
            end
        end
    endtask

    task automatic en_step();
        clk_en = 1'b1;
        step();
        clk_en = 1'b0;
    endtask

    task automatic test_clk_en();
        Op_st g02 = mk_op(CMD_G02, -3, 4, 1, 1, 8'd1);
        op_in    = g02;
        op_valid = 1'b1;
        clk_en   = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0 || op_rdy !== 1'b1 || err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL gate_no_accept: got busy=%b op_rdy=%b err=%b exp 0/1/1", busy, op_rdy, err_timeout);
        end
        en_step();
        op_valid = 1'b0;
        n_checks++; if (circ_if.trigger !== 1'b1 || err_timeout !== 1'b0 || op !== g02) begin
            n_fail++; $display("FAIL gate_accept: got trig=%b err=%b op=%h exp 1/0/%h", circ_if.trigger, err_timeout, op, g02);
        end
        hold2(1'b1, 1'b0);
        circ_if.rdy = 1'b0;
        en_step();
        n_checks++; if (circ_if.trigger !== 1'b0) begin n_fail++; $display("FAIL gate_trig_fall: got %b exp 0", circ_if.trigger); end
        hold2(1'b0, 1'b0);
        circ_if.rdy = 1'b1;
        en_step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL gate_done: got %b exp 1", done); end
        hold2(1'b0, 1'b1);
        en_step();
        n_checks++; if (done !== 1'b0 || op_rdy !== 1'b1) begin
            n_fail++; $display("FAIL gate_idle: got done=%b op_rdy=%b exp 0/1", done, op_rdy);
        end
        clk_en = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        Op_st g02a = mk_op(CMD_G02, 11, 12, 13, 14, 8'd1);
        Op_st g02b = mk_op(CMD_G02, 21, 22, 23, 24, 8'd1);
        offer(g02a);
        circ_if.rdy = 1'b0;
        step();
        n_checks++; if (circ_if.trigger !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_wait: got trig=%b busy=%b exp 0/1", circ_if.trigger, busy);
        end
        reset  = 1'b0;
        clk_en = 1'b0;
        step();
        n_checks++; if (op !== '0 || op_rdy !== 1'b0 || {busy, done, circ_if.trigger, lin_if.trigger} !== 4'b0) begin
            n_fail++; $display("FAIL rst_mid: got op=%h op_rdy=%b busy=%b done=%b exp 0/0/0/0", op, op_rdy, busy, done);
        end
        reset       = 1'b1;
        clk_en      = 1'b1;
        circ_if.rdy = 1'b1;
        step();
        n_checks++; if (op_rdy !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_release: got op_rdy=%b busy=%b exp 1/0", op_rdy, busy);
        end
        offer(g02b);
        n_checks++; if (circ_if.trigger !== 1'b1 || op !== g02b) begin
            n_fail++; $display("FAIL rst_fresh_accept: got trig=%b op=%h exp 1/%h", circ_if.trigger, op, g02b);
        end
        circ_if.rdy = 1'b0;
        step();
        circ_if.rdy = 1'b1;
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_done: got %b exp 1", done); end
        step();
    endtask

    initial begin
        reset       = 1'b0;
        clk_en      = 1'b1;
        op_valid    = 1'b0;
        op_in       = '0;
        lin_if.rdy  = 1'b1;
        circ_if.rdy = 1'b1;
        test_reset();
        test_circular();
        test_back_to_back();
        test_mode();
        test_unsupported();
        test_timeout();
        test_clk_en();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
